store_merge_unit: RTL
=====================

Name: store_merge_unit

Overview:
- Sits between the multicycle control unit and the unified instruction/data memory, on the store path.
- On start, performs a word store directly.
- Byte and halfword stores become a read-modify-write: fetch the old word, merge the new lane(s), write the whole word back.
- The control unit's fixed store wait states are replaced by a start/busy/done handshake.

Parameters:
- READ_LAT, 2, memory read latency in cycles. Allowed range 1..15. mem_rdata is valid in the last READ cycle.
- ADDR_W, 32, byte address width.

Ports:
- clk         input   1       system clock, rising edge
- rst         input   1       asynchronous reset, active-high
- start       input   1       request pulse; sampled only in IDLE
- addr        input   ADDR_W  byte address of the store (ALUOut)
- wdata       input   32      store data (regB); byte in [7:0], half in [15:0]
- memow_ctrl  input   2       0 = word, 1 = byte, 2 = half, 3 = reserved (treated as word)
- mem_rdata   input   32      word read from memory
- mem_addr    output  ADDR_W  word-aligned address {addr[ADDR_W-1:2], 2'b00}
- mem_wdata   output  32      merged word to memory
- mem_we      output  1       memory write enable
- busy        output  1       high whenever state != IDLE
- done        output  1       one-cycle completion pulse

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - All outputs 0: mem_we, busy, done, mem_addr, mem_wdata.
  - Internal latches 0: addr_q, data_q, ctrl_q, old_q, lat_cnt.
- Outputs are decoded from registered state and registers only. No combinational input-to-output path.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If start = 1 at edge k, latch addr_q, data_q and ctrl_q.
  - Next state is READ for byte/half, WRITE for word/reserved.
  - If start = 0, stay in IDLE.
- READ:
  - mem_addr is the aligned address; mem_we = 0.
  - lat_cnt counts 0..READ_LAT-1.
  - On the edge ending the last READ cycle, old_q <= mem_rdata and go to WRITE.
- WRITE:
  - Lasts exactly one cycle, with mem_we = 1 and mem_addr aligned.
  - mem_wdata is data_q for a word.
  - Otherwise it is old_q with the selected lane replaced, lanes little-endian (offset 0 = bits [7:0]):
    - byte, addr_q[1:0] = n: bits [8n+7:8n] <= data_q[7:0].
    - half, addr_q[1] = 0: bits [15:0] <= data_q[15:0].
    - half, addr_q[1] = 1: bits [31:16] <= data_q[15:0].
  - addr_q[0] is ignored for halves; addr_q[1:0] is ignored for words. No misalignment trap.
- DONE: lasts one cycle with done = 1, then returns to IDLE.
- Latency from the start edge to the done cycle:
  - word: 2 cycles (WRITE, DONE).
  - byte/half: READ_LAT + 2 cycles.
- Handshake:
  - start while busy is ignored; no queueing.
  - addr, wdata and memow_ctrl may change freely after the start edge.
  - A new start is accepted in the IDLE cycle after DONE.
- Reset mid-operation:
  - Immediately forces IDLE and deasserts mem_we.
  - A partial write never completes; the memory word keeps its prior value unless the WRITE cycle had already been sampled.
- mem_wdata holds its last value outside WRITE. It is don't-care to memory but must not glitch during WRITE.

Decomposition:
- Shared package (cpu_pkg):
  - memow_ctrl encodings MEMOW_WORD = 2'd0, MEMOW_BYTE = 2'd1, MEMOW_HALF = 2'd2.
  - State encoding for this FSM.
  - The same package holds the adjsz_ctrl encodings used by the load path.
- Sub-module lane_merge: purely combinational. Inputs: old word, new data, ctrl, addr[1:0]. Output: merged word. Reused later by a load-extract counterpart.

Test Plan:
- Word store: READ_LAT = 2, addr = 0x0000_0104, wdata = 0xDEAD_BEEF, ctrl = 0 → mem_we high exactly 1 cycle after start, mem_addr = 0x104, mem_wdata = 0xDEAD_BEEF; done next cycle; no READ cycles.
- Byte store: mem word at 0x100 = 0x1122_3344, addr = 0x102, wdata = 0x0000_00AA, ctrl = 1 → 2 READ cycles, then WRITE of 0x11AA_3344 at 0x100; done at start + 4.
- Halfword store:
  - addr = 0x103 (odd, upper half), wdata = 0x0000_BEEF, old word 0x1122_3344 → write 0xBEEF_3344.
  - Repeat with addr = 0x100 → write 0x1122_BEEF.
- Start while busy: start pulses at cycles 1 and 2 with a byte store → only one WRITE and one done; the second request is ignored.
- Reset mid-READ: assert rst during lat_cnt = 0 of a byte store → state IDLE and busy = 0 at once, no mem_we pulse, memory unchanged; the next start completes normally.
- Latency sweep: READ_LAT = 1 and READ_LAT = 15 with a byte store at offset 3 → done at start + 3 and start + 17; bits [31:24] replaced.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: memory-path control encodings and store-merge FSM states
package cpu_pkg;
  localparam logic [1:0] MEMOW_WORD = 2'd0;
  localparam logic [1:0] MEMOW_BYTE = 2'd1;
  localparam logic [1:0] MEMOW_HALF = 2'd2;
  localparam logic [1:0] ADJSZ_WORD = 2'd0;
  localparam logic [1:0] ADJSZ_BYTE = 2'd1;
  localparam logic [1:0] ADJSZ_HALF = 2'd2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// lane_merge: replaces the byte/half lane of a word selected by offset; word/reserved pass new data
module lane_merge
  import cpu_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  ctrl_i,
  input  logic [1:0]  ofs_i,
  output logic [31:0] merged_o
);
  always_comb begin
    merged_o = old_i;
    if (ctrl_i == MEMOW_BYTE) merged_o[{ofs_i, 3'b000} +: 8] = data_i[7:0];
    else if (ctrl_i == MEMOW_HALF) merged_o[{ofs_i[1], 4'b0000} +: 16] = data_i[15:0];
    else merged_o = data_i;
  end
endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: word stores go straight to memory, byte/half stores do read-modify-write
module store_merge_unit
  import cpu_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        memow_ctrl,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);
  logic [1:0]        state_q, state_d, ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q, old_q, hold_q, merged;
  logic [3:0]        lat_cnt_q;
  logic              last, is_sub;
  assign last   = lat_cnt_q == 4'(READ_LAT - 1);
  assign is_sub = memow_ctrl == MEMOW_BYTE || memow_ctrl == MEMOW_HALF;
  always_comb begin
    state_d = state_q == S_IDLE  ? (start ? (is_sub ? S_READ : S_WRITE) : S_IDLE)
            : state_q == S_READ  ? (last ? S_WRITE : S_READ)
            : state_q == S_WRITE ? S_DONE : S_IDLE;
  end
  lane_merge u_merge (
    .old_i(old_q), .data_i(data_q), .ctrl_i(ctrl_q), .ofs_i(addr_q[1:0]), .merged_o(merged)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      ctrl_q    <= '0;
      old_q     <= '0;
      hold_q    <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        addr_q <= addr;
        data_q <= wdata;
        ctrl_q <= memow_ctrl;
      end
      if (state_q == S_READ) begin
        lat_cnt_q <= last ? '0 : lat_cnt_q + 4'd1;
        if (last) old_q <= mem_rdata;
      end
      if (state_q == S_WRITE) hold_q <= merged;
    end
  end
  // merged is built only from registers, so it is stable for the whole WRITE cycle
  assign mem_we    = state_q == S_WRITE;
  assign mem_wdata = mem_we ? merged : hold_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
endmodule
